hood_mode_ctrl: RTL and testbench

HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

---
 rtl/hood_pkg.sv | 33 +++
 rtl/btn_conditioner.sv | 83 ++++++++
 rtl/hood_mode_ctrl.sv | 131 +++++++++++++
 tb/tb_hood_mode_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// hood_pkg: shared definitions for the range-hood mode controller.
//   - MODE_* : mode_state encoding, also decoded by the downstream fan/timer stage
//   - hood_state_t : controller FSM state enum
//   - cnt_width() : width of a counter that must hold 0 .. limit-1
package hood_pkg;

    localparam logic [2:0] MODE_STBY = 3'b000;
    localparam logic [2:0] MODE_L1   = 3'b001;
    localparam logic [2:0] MODE_L2   = 3'b010;
    localparam logic [2:0] MODE_L3   = 3'b011;

    typedef enum logic [2:0] {
        ST_STBY,
        ST_MENU,
        ST_L1,
        ST_L2,
        ST_L3
    } hood_state_t;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic logic [2:0] mode_of(input hood_state_t s);
        case (s)
            ST_L1:   return MODE_L1;
            ST_L2:   return MODE_L2;
            ST_L3:   return MODE_L3;
            default: return MODE_STBY;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns one raw push-button into a single-cycle press pulse.
//   2-flop synchronizer -> optional debounce filter -> rising-edge detector.
// Build option: HOOD_MODE_DEBOUNCE_EN adds the debounce filter; without it the
//   synchronized level feeds the edge detector directly.
// Ports:
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   btn_raw     in  raw asynchronous button, high while pressed
//   press_pulse out one-cycle pulse per accepted press
module btn_conditioner
    import hood_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic level;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef HOOD_MODE_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    // Count consecutive cycles where the synchronized input disagrees with
    // the accepted level; any agreement clears the count, so a bounce
    // restarts the wait.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    assign press_pulse = level & ~prev_q;

endmodule

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl: range-hood fan mode controller (standby / menu / 3 levels).
// Build option: HOOD_MODE_DEBOUNCE_EN enables button debounce filtering.
// Ports:
//   clk             in  system clock, rising edge
//   rst             in  asynchronous active-high reset
//   menu_btn        in  raw menu button
//   mode1_btn       in  raw level-1 button
//   mode2_btn       in  raw level-2 button
//   mode3_btn       in  raw hurricane button
//   mode_state[2:0] out 000 standby, 001 L1, 010 L2, 011 hurricane
//   menu_active     out high while in MENU
//   hurricane_used  out sticky, set on first hurricane entry
//
// state | meaning
// ------+--------------------------------------------------
// STBY  | fan off, waits for menu
// MENU  | selection menu, idle timeout back to STBY
// L1    | fan level 1
// L2    | fan level 2
// L3    | hurricane, timed dwell then drops to L2
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 10,
    parameter int MENU_TIMEOUT_CYCLES = 5000,
    parameter int HURRICANE_CYCLES    = 30000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       menu_btn,
    input  logic       mode1_btn,
    input  logic       mode2_btn,
    input  logic       mode3_btn,
    output logic [2:0] mode_state,
    output logic       menu_active,
    output logic       hurricane_used
);

    localparam int MW = cnt_width(MENU_TIMEOUT_CYCLES);
    localparam int HW = cnt_width(HURRICANE_CYCLES);
    localparam logic [MW-1:0] MENU_LAST = MW'(MENU_TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HURR_LAST = HW'(HURRICANE_CYCLES - 1);

    logic menu_p, mode1_p, mode2_p, mode3_p;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_menu (
        .clk(clk), .rst(rst), .btn_raw(menu_btn),  .press_pulse(menu_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode1 (
        .clk(clk), .rst(rst), .btn_raw(mode1_btn), .press_pulse(mode1_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode2 (
        .clk(clk), .rst(rst), .btn_raw(mode2_btn), .press_pulse(mode2_p));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode3 (
        .clk(clk), .rst(rst), .btn_raw(mode3_btn), .press_pulse(mode3_p));

    hood_state_t   state_q, state_d;
    logic [MW-1:0] menu_cnt_q, menu_cnt_d;
    logic [HW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic          hu_q, hu_d;

    // Pulses are priority-resolved (menu > mode3 > mode2 > mode1) before the
    // state acts on them, so a masked lower pulse never acts in the same
    // cycle. Both counters default to zero, which clears them on every exit
    // and on any pulse seen in MENU.
    always_comb begin
        state_d     = state_q;
        menu_cnt_d  = '0;
        dwell_cnt_d = '0;
        hu_d        = hu_q;
        case (state_q)
            ST_STBY: begin
                if (menu_p) state_d = ST_MENU;
            end
            ST_MENU: begin
                if (menu_p) begin
                    state_d = ST_STBY;
                end else if (mode3_p) begin
                    if (!hu_q) state_d = ST_L3;
                end else if (mode2_p) begin
                    state_d = ST_L2;
                end else if (mode1_p) begin
                    state_d = ST_L1;
                end else if (menu_cnt_q == MENU_LAST) begin
                    state_d = ST_STBY;
                end else begin
                    menu_cnt_d = menu_cnt_q + 1'b1;
                end
            end
            ST_L1, ST_L2: begin
                if (menu_p) begin
                    state_d = ST_STBY;
                end else if (mode3_p) begin
                    if (!hu_q) state_d = ST_L3;
                end else if (mode2_p) begin
                    state_d = ST_L2;
                end else if (mode1_p) begin
                    state_d = ST_L1;
                end
            end
            ST_L3: begin
                if (menu_p) begin
                    state_d = ST_STBY;
                end else if (dwell_cnt_q == HURR_LAST) begin
                    state_d = ST_L2;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_STBY;
        endcase
        if ((state_d == ST_L3) && (state_q != ST_L3)) hu_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_STBY;
            menu_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            hu_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            menu_cnt_q  <= menu_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            hu_q        <= hu_d;
        end
    end

    assign mode_state     = mode_of(state_q);
    assign menu_active    = (state_q == ST_MENU);
    assign hurricane_used = hu_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model of the hood controller.
module tb_hood_mode_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 20;
    localparam int HC  = 50;
`ifdef HOOD_MODE_DEBOUNCE_EN
    localparam int D_EFF = DEB;
`else
    localparam int D_EFF = 0;
`endif
    // edges from driving a raw press to the state change it causes
    localparam int LAT = 3 + D_EFF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       menu_btn = 1'b0, mode1_btn = 1'b0, mode2_btn = 1'b0, mode3_btn = 1'b0;
    logic [2:0] mode_state;
    logic       menu_active, hurricane_used;

    int vectors     = 0;
    int miscompares = 0;

    // behavioural model
    int       cyc = 0;
    bit [15:0] hist [4];
    bit        lvl [4];
    bit        lvl_prev [4];
    int        m_mode;
    bit        m_menu, m_hu;
    int        menu_ref, l3_ref;

    hood_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .MENU_TIMEOUT_CYCLES(TO),
        .HURRICANE_CYCLES(HC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .menu_btn(menu_btn),
        .mode1_btn(mode1_btn),
        .mode2_btn(mode2_btn),
        .mode3_btn(mode3_btn),
        .mode_state(mode_state),
        .menu_active(menu_active),
        .hurricane_used(hurricane_used)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            hist[b]     = '0;
            lvl[b]      = 1'b0;
            lvl_prev[b] = 1'b0;
        end
        m_mode = 0;
        m_menu = 1'b0;
        m_hu   = 1'b0;
    endtask

    task automatic enter_l3();
        m_mode = 3;
        m_hu   = 1'b1;
        l3_ref = cyc;
    endtask

    // p[0]=menu p[1]=mode1 p[2]=mode2 p[3]=mode3
    task automatic model_fsm(input bit [3:0] p);
        if (m_menu) begin
            if (p[0]) m_menu = 1'b0;
            else if (p[3]) begin
                if (!m_hu) begin m_menu = 1'b0; enter_l3(); end
                else menu_ref = cyc;
            end
            else if (p[2]) begin m_menu = 1'b0; m_mode = 2; end
            else if (p[1]) begin m_menu = 1'b0; m_mode = 1; end
            else if (cyc - menu_ref >= TO) m_menu = 1'b0;
        end else begin
            case (m_mode)
                0: if (p[0]) begin m_menu = 1'b1; menu_ref = cyc; end
                1, 2: begin
                    if (p[0]) m_mode = 0;
                    else if (p[3]) begin if (!m_hu) enter_l3(); end
                    else if (p[2]) m_mode = 2;
                    else if (p[1]) m_mode = 1;
                end
                default: begin
                    if (p[0]) m_mode = 0;
                    else if (cyc - l3_ref >= HC) m_mode = 2;
                end
            endcase
        end
    endtask

    // One rising edge: a press is accepted once the synchronized raw level
    // (raw delayed two edges) has held the opposite value for a full window.
    task automatic model_edge();
        bit [3:0] raw;
        bit [3:0] p;
        bit       flip;
        raw = {mode3_btn, mode2_btn, mode1_btn, menu_btn};
        cyc++;
        for (int b = 0; b < 4; b++) begin
            p[b] = lvl[b] & ~lvl_prev[b];
            hist[b] = {hist[b][14:0], raw[b]};
            lvl_prev[b] = lvl[b];
`ifdef HOOD_MODE_DEBOUNCE_EN
            flip = 1'b1;
            for (int k = 2; k <= D_EFF + 1; k++)
                if (hist[b][k] == lvl[b]) flip = 1'b0;
            if (flip) lvl[b] = ~lvl[b];
`else
            flip = 1'b0;
            lvl[b] = hist[b][1] | flip;
`endif
        end
        model_fsm(p);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        expect_val({tag, ".mode_state"},     32'(mode_state),     32'(m_mode));
        expect_val({tag, ".menu_active"},    32'(menu_active),    32'(m_menu));
        expect_val({tag, ".hurricane_used"}, 32'(hurricane_used), 32'(m_hu));
    endtask

    task automatic drive(input logic [3:0] v);
        {mode3_btn, mode2_btn, mode1_btn, menu_btn} = v;
    endtask

    task automatic idle(input int n, input string tag);
        drive(4'b0000);
        repeat (n) tick(tag);
    endtask

    // hold v until the edge where its press acts, then release
    task automatic press(input logic [3:0] v, input string tag);
        drive(v);
        repeat (LAT) tick(tag);
        drive(4'b0000);
    endtask

    task automatic do_reset(input string tag);
        drive(4'b0000);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_val({tag, ".rst_mode"}, 32'(mode_state),     32'd0);
        expect_val({tag, ".rst_menu"}, 32'(menu_active),    32'd0);
        expect_val({tag, ".rst_hu"},   32'(hurricane_used), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] v;
        int r;
        model_reset();
        do_reset("init");

        // menu press: MENU exactly LAT edges after the press, held button gives one pulse
        drive(4'b0001);
        repeat (LAT - 1) tick("menu_lat");
        expect_val("menu_lat.before", 32'(menu_active), 32'd0);
        tick("menu_lat");
        expect_val("menu_lat.at", 32'(menu_active), 32'd1);
        repeat (5) tick("menu_hold");
        expect_val("menu_hold.single", 32'(menu_active), 32'd1);
        drive(4'b0100);
        repeat (LAT - 1) tick("mode2_lat");
        expect_val("mode2_lat.before", 32'(mode_state), 32'd0);
        tick("mode2_lat");
        expect_val("mode2_lat.at", 32'(mode_state), 32'd2);
        repeat (10 - LAT) tick("mode2_hold");
        expect_val("mode2_hold.single", 32'(mode_state), 32'd2);
        idle(LAT + 2, "gap");
        press(4'b0001, "menu_exit");
        expect_val("l2_menu.stby", 32'(mode_state), 32'd0);
        idle(LAT + 2, "gap");

        // menu timeout exactly TO edges after entry
        press(4'b0001, "to_enter");
        repeat (TO - 1) tick("to_wait");
        expect_val("timeout.before", 32'(menu_active), 32'd1);
        tick("to_wait");
        expect_val("timeout.at", 32'(menu_active), 32'd0);
        idle(LAT + 2, "gap");

        // hurricane: entry, dwell of HC edges, no re-entry
        press(4'b0001, "h_menu");
        press(4'b0010, "h_l1");
        expect_val("h_l1.mode", 32'(mode_state), 32'd1);
        press(4'b1000, "h_l3");
        expect_val("h_l3.mode", 32'(mode_state), 32'd3);
        expect_val("h_l3.hu",   32'(hurricane_used), 32'd1);
        repeat (HC - 1) tick("h_dwell");
        expect_val("dwell.before", 32'(mode_state), 32'd3);
        tick("h_dwell");
        expect_val("dwell.at", 32'(mode_state), 32'd2);
        press(4'b1000, "h_again");
        idle(3, "h_again");
        expect_val("h_again.mode", 32'(mode_state), 32'd2);
        press(4'b0001, "h_exit");
        idle(LAT + 2, "gap");

        // menu timeout restarted by an ignored mode3 pulse at idle cycle 19
        press(4'b0001, "rs_enter");
        idle(TO - 1 - LAT, "rs_wait");
        press(4'b1000, "rs_m3");
        expect_val("restart.in_menu", 32'(menu_active), 32'd1);
        repeat (TO - 1) tick("rs_wait2");
        expect_val("restart.before", 32'(menu_active), 32'd1);
        tick("rs_wait2");
        expect_val("restart.at", 32'(menu_active), 32'd0);

        // simultaneous menu + mode3 in L2: menu wins
        do_reset("sim");
        press(4'b0001, "sim_menu");
        press(4'b0100, "sim_l2");
        idle(LAT + 2, "gap");
        press(4'b1001, "sim_both");
        expect_val("sim.mode", 32'(mode_state), 32'd0);
        expect_val("sim.hu",   32'(hurricane_used), 32'd0);
        idle(LAT + 2, "gap");

        // asynchronous reset mid-hurricane
        do_reset("ar");
        press(4'b0001, "ar_menu");
        press(4'b1000, "ar_l3");
        repeat (25) tick("ar_dwell");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        expect_val("async_rst.mode", 32'(mode_state),     32'd0);
        expect_val("async_rst.hu",   32'(hurricane_used), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        press(4'b0001, "ar_menu2");
        press(4'b1000, "ar_l3b");
        expect_val("ar_again.mode", 32'(mode_state), 32'd3);
        expect_val("ar_again.hu",   32'(hurricane_used), 32'd1);

        // bounced menu press then mode2 held 10 cycles
        do_reset("bnc");
        drive(4'b0001); tick("bnc");
        drive(4'b0000); tick("bnc");
        drive(4'b0001); repeat (10) tick("bnc");
        drive(4'b0100); repeat (10) tick("bnc");
        idle(LAT + 2, "bnc");
`ifdef HOOD_MODE_DEBOUNCE_EN
        expect_val("bounce.mode", 32'(mode_state), 32'd2);
`endif

        // randomized button activity
        do_reset("rnd");
        for (int i = 0; i < 240; i++) begin
            if (i == 120) do_reset("rnd_mid");
            r = $urandom_range(0, 9);
            if (r < 4)      v = 4'b0000;
            else if (r < 8) v = 4'b0001 << $urandom_range(0, 3);
            else            v = 4'($urandom_range(0, 15));
            drive(v);
            repeat ($urandom_range(1, 12)) tick("rnd");
        end
        idle(10, "end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
